// File: rtl/reg_file_sb_if.sv
// Bundle of the ID read ports, the scoreboard issue port, the WB write port and the
// status outputs of reg_file_sb. The pipeline drives it through master; the register file uses slave.
interface reg_file_sb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] rs1_value;
  logic [DATA_W-1:0] rs2_value;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              issue;
  logic [ADDR_W-1:0] issue_rd;
  logic              wen;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] rd_value;
  logic              flush;
  logic [DATA_W-1:0] a0_value;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rs1, rs2, issue, issue_rd, wen, rd, rd_value, flush,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, a0_value, stall_cnt
  );

  modport slave (
    input  rs1, rs2, issue, issue_rd, wen, rd, rd_value, flush,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, a0_value, stall_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with a per-register busy scoreboard: two async read ports, one WB write port.
// Define REG_FILE_BYPASS_EN to forward the WB write straight to the read ports (0-cycle latency).
module reg_file_sb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int A0_IDX = 10,
  parameter int CNT_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  reg_file_sb_if.slave   bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] A0_SEL = ADDR_W'(A0_IDX);
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic wr_hit;
  logic iss_hit;

  // x0 is never written nor marked busy, so it reads 0 without any read-side masking.
  assign wr_hit  = bus.wen && (bus.rd != '0);
  assign iss_hit = bus.issue && (bus.issue_rd != '0) && !bus.flush;

  logic [DATA_W-1:0] rs1_value_c;
  logic [DATA_W-1:0] rs2_value_c;
  logic              rs1_busy_c;
  logic              rs2_busy_c;

  always_comb begin
    rs1_value_c = regs[bus.rs1];
    rs2_value_c = regs[bus.rs2];
    rs1_busy_c  = busy[bus.rs1];
    rs2_busy_c  = busy[bus.rs2];
`ifdef REG_FILE_BYPASS_EN
    // A younger producer issued this cycle keeps the register busy even while WB forwards.
    if (wr_hit && (bus.rd == bus.rs1)) begin
      rs1_value_c = bus.rd_value;
      if (!(iss_hit && (bus.issue_rd == bus.rs1))) rs1_busy_c = 1'b0;
    end
    if (wr_hit && (bus.rd == bus.rs2)) begin
      rs2_value_c = bus.rd_value;
      if (!(iss_hit && (bus.issue_rd == bus.rs2))) rs2_busy_c = 1'b0;
    end
`endif
  end

  assign bus.rs1_value = rs1_value_c;
  assign bus.rs2_value = rs2_value_c;
  assign bus.rs1_busy  = rs1_busy_c;
  assign bus.rs2_busy  = rs2_busy_c;
  assign bus.a0_value  = regs[A0_SEL];
  assign bus.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy        <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (wr_hit) regs[bus.rd] <= bus.rd_value;
      // The issue set is written after the WB clear so a same-index collision leaves it busy.
      if (bus.flush) begin
        busy <= '0;
      end else begin
        if (wr_hit)  busy[bus.rd]       <= 1'b0;
        if (iss_hit) busy[bus.issue_rd] <= 1'b1;
      end
      if ((rs1_busy_c || rs2_busy_c) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios then random traffic against a
// behavioural model of the register array, the scoreboard and the saturating stall counter.
module tb_reg_file_sb;
  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int CW   = 5;
  localparam int NREG = 2 ** AW;
  localparam int A0   = 10;
  localparam int unsigned STALL_MAX = (1 << CW) - 1;

  logic clk;
  logic rst;

  reg_file_sb_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  reg_file_sb #(.ADDR_W(AW), .DATA_W(DW), .A0_IDX(A0), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_regs [NREG];
  bit            m_busy [NREG];
  int unsigned   m_stall;
  int            n_checks;
  int            n_pass;

  logic [AW-1:0] s_rs1, s_rs2, s_issue_rd, s_rd;
  logic          s_issue, s_wen, s_flush;
  logic [DW-1:0] s_rd_value;

  function automatic void modelReset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_stall = 0;
  endfunction

  function automatic logic [DW-1:0] expValue(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (s_wen && s_rd == idx) return s_rd_value;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic expBusy(input logic [AW-1:0] idx);
    if (idx == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (s_wen && s_rd == idx && !(s_issue && !s_flush && s_issue_rd == idx)) return 1'b0;
`endif
    return m_busy[idx];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkOutput();
    check("rs1_value", bus.rs1_value, expValue(s_rs1));
    check("rs2_value", bus.rs2_value, expValue(s_rs2));
    check("rs1_busy",  DW'(bus.rs1_busy), DW'(expBusy(s_rs1)));
    check("rs2_busy",  DW'(bus.rs2_busy), DW'(expBusy(s_rs2)));
    check("a0_value",  bus.a0_value, m_regs[A0]);
    check("stall_cnt", DW'(bus.stall_cnt), DW'(m_stall));
  endtask

  // Drive one cycle of inputs, check the combinational view, then advance model and DUT together.
  task automatic applyStimulus(input logic rst_v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic issue, input logic [AW-1:0] issue_rd,
                               input logic wen, input logic [AW-1:0] rd, input logic [DW-1:0] rd_value,
                               input logic flush);
    bit stalled;
    rst = rst_v;
    s_rs1 = rs1; s_rs2 = rs2; s_issue = issue; s_issue_rd = issue_rd;
    s_wen = wen; s_rd = rd; s_rd_value = rd_value; s_flush = flush;
    bus.rs1 = rs1; bus.rs2 = rs2; bus.issue = issue; bus.issue_rd = issue_rd;
    bus.wen = wen; bus.rd = rd; bus.rd_value = rd_value; bus.flush = flush;
    #1;
    checkOutput();
    stalled = expBusy(rs1) || expBusy(rs2);
    @(posedge clk);
    if (!rst_v) begin
      modelReset();
    end else begin
      if (stalled && m_stall < STALL_MAX) m_stall++;
      if (wen && rd != 0) m_regs[rd] = rd_value;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      end else begin
        if (wen && rd != 0) m_busy[rd] = 1'b0;
        if (issue && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    n_checks = 0;
    n_pass = 0;
    bus.rs1 = '0; bus.rs2 = '0; bus.issue = 1'b0; bus.issue_rd = '0;
    bus.wen = 1'b0; bus.rd = '0; bus.rd_value = '0; bus.flush = 1'b0;
    s_rs1 = '0; s_rs2 = '0; s_issue = 1'b0; s_issue_rd = '0;
    s_wen = 1'b0; s_rd = '0; s_rd_value = '0; s_flush = 1'b0;
    modelReset();
    @(posedge clk);
    @(negedge clk);

    // reset clears a written register, busy bits and the counter
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
    applyStimulus(1, 5, 0, 1, 5, 0, 0, 0, 0);
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 1, 6, 1, 6, 32'h1, 1);
    applyStimulus(1, 5, 6, 0, 0, 0, 0, 0, 0);

    // x0 ignores writes and issues
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW hazard on x7
    applyStimulus(1, 0, 0, 1, 7, 0, 0, 0, 0);
    applyStimulus(1, 0, 7, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 7, 0, 0, 1, 7, 32'h1234, 0);
    applyStimulus(1, 0, 7, 0, 0, 0, 0, 0, 0);

    // issue/WB collision on x3
    applyStimulus(1, 0, 0, 1, 3, 0, 0, 0, 0);
    applyStimulus(1, 3, 0, 1, 3, 1, 3, 32'h55, 0);
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 32'h66, 0);

    // flush drops outstanding producers and a same-cycle issue
    applyStimulus(1, 0, 0, 1, 8, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 9, 0, 0, 0, 0);
    applyStimulus(1, 8, 9, 1, 10, 1, 2, 32'hABCD, 1);
    applyStimulus(1, 8, 9, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 10, 2, 0, 0, 0, 0, 0, 0);

    // a0 export
    applyStimulus(1, 0, 0, 0, 0, 1, 10, 32'h1, 0);
    applyStimulus(1, 10, 0, 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    AW'($urandom_range(0, NREG-1)), AW'($urandom_range(0, NREG-1)),
                    ($urandom_range(0, 2) == 0), AW'($urandom_range(0, NREG-1)),
                    ($urandom_range(0, 2) == 0), AW'($urandom_range(0, NREG-1)), DW'($urandom()),
                    ($urandom_range(0, 19) == 0));
    end

    // stall counter saturates instead of wrapping
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 4, 0, 0, 0, 0);
    for (int n = 0; n < 40; n++) applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
